// File: rtl/pif_regdecode_pkg.sv
// pif_regdecode_pkg: shared tag codes, register indices and FSM state type for the I2C register decoder
package pif_regdecode_pkg;
  localparam int I2C_DATA_BITS = 6;
  localparam logic [1:0] A_ADDR = 2'b00;
  localparam logic [1:0] D_ADDR = 2'b01;
  localparam int REG_ID = 0;
  localparam int REG_SCRATCH = 1;
  localparam int REG_LED = 2;
  typedef enum logic [1:0] {IDLE, ARMED, DROP} state_t;
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction
endpackage

// File: rtl/pif_regdecode_if.sv
// pif_regdecode_if: received-byte stream in, register contents and status out
interface pif_regdecode_if;
  import pif_regdecode_pkg::*;
  logic                     RX_VALID;
  logic [7:0]               RX_DATA;
  logic                     RX_STOP;
  logic [I2C_DATA_BITS-1:0] LED_CTRL;
  logic [I2C_DATA_BITS-1:0] SCRATCH;
  logic                     WR_STB;
  logic [7:0]               RD_DATA;
  logic [3:0]               ERR_CNT;
  modport master (output RX_VALID, RX_DATA, RX_STOP, input LED_CTRL, SCRATCH, WR_STB, RD_DATA, ERR_CNT);
  modport slave  (input RX_VALID, RX_DATA, RX_STOP, output LED_CTRL, SCRATCH, WR_STB, RD_DATA, ERR_CNT);
endinterface

// File: rtl/pif_regdecode.sv
// pif_regdecode: decodes tagged I2C write bytes into an address/data register file; REGDEC_AUTOINC_EN enables address auto-increment
module pif_regdecode
  import pif_regdecode_pkg::*;
#(
  parameter int                       NUM_REGS = 4,
  parameter logic [I2C_DATA_BITS-1:0] ID_VALUE = 6'h2A
) (
  input logic            CLK,
  input logic            RST,
  pif_regdecode_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  state_t                   state_q, state_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic [I2C_DATA_BITS-1:0] regs_q [NUM_REGS];
  logic [I2C_DATA_BITS-1:0] regs_d [NUM_REGS];
  logic [3:0]               err_q, err_d;
  logic                     wr_stb_q, wr_stb_d;
  logic [1:0]               tag;
  logic [I2C_DATA_BITS-1:0] pay;
  logic                     in_range;
  assign tag = bus.RX_DATA[7:6];
  assign pay = bus.RX_DATA[I2C_DATA_BITS-1:0];
  assign in_range = {1'b0, pay} < 7'(NUM_REGS);
  // byte decode first, then STOP overrides the next state so a coincident byte is still processed
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    regs_d = regs_q;
    err_d = err_q;
    wr_stb_d = 1'b0;
    if (bus.RX_VALID) begin
      if (tag == A_ADDR && in_range) begin
        addr_d = pay[AW-1:0];
        state_d = ARMED;
      end else if (tag == A_ADDR) begin
        err_d = sat_inc(err_q);
        state_d = DROP;
      end else if (tag == D_ADDR && state_q == ARMED) begin
        if (addr_q != '0) begin
          regs_d[addr_q] = pay;
          wr_stb_d = 1'b1;
`ifdef REGDEC_AUTOINC_EN
          addr_d = (addr_q == AW'(NUM_REGS - 1)) ? AW'(1) : addr_q + AW'(1);
`else
          addr_d = addr_q;
`endif
        end
      end else begin
        err_d = sat_inc(err_q);
      end
    end
    if (bus.RX_STOP) state_d = IDLE;
  end
  // state, address, register file and status registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q <= '0;
      regs_q <= '{default: '0};
      err_q <= '0;
      wr_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      regs_q <= regs_d;
      err_q <= err_d;
      wr_stb_q <= wr_stb_d;
    end
  end
  assign bus.RD_DATA = {2'b01, (addr_q == '0) ? ID_VALUE : regs_q[addr_q]};
  assign bus.SCRATCH = regs_q[REG_SCRATCH];
  assign bus.WR_STB = wr_stb_q;
  assign bus.ERR_CNT = err_q;
  if (NUM_REGS > REG_LED) begin : g_led
    assign bus.LED_CTRL = regs_q[REG_LED];
  end else begin : g_noled
    assign bus.LED_CTRL = '0;
  end
endmodule

// File: tb/tb_pif_regdecode.sv
// tb_pif_regdecode: directed and random byte streams checked against a behavioural model
module tb_pif_regdecode;
  localparam int NR = 4;
  localparam logic [5:0] IDV = 6'h2A;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  pif_regdecode_if bus ();
  pif_regdecode #(.NUM_REGS(NR), .ID_VALUE(IDV)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  int compared = 0;
  int mismatched = 0;
  int m_state, m_addr, m_err;
  int m_reg [64];
  bit m_wr;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // model: 0=idle 1=armed 2=drop; registers as plain ints
  task automatic model(input bit r, input bit v, input logic [7:0] d, input bit s);
    int t, p;
    if (r) begin
      m_state = 0; m_addr = 0; m_err = 0; m_wr = 0;
      for (int i = 0; i < 64; i++) m_reg[i] = 0;
      return;
    end
    m_wr = 0;
    t = int'(d) / 64;
    p = int'(d) % 64;
    if (v) begin
      if (t == 0 && p < NR) begin
        m_addr = p; m_state = 1;
      end else if (t == 0) begin
        m_err = (m_err < 15) ? m_err + 1 : 15; m_state = 2;
      end else if (t == 1 && m_state == 1) begin
        if (m_addr != 0) begin
          m_reg[m_addr] = p; m_wr = 1;
`ifdef REGDEC_AUTOINC_EN
          m_addr = (m_addr + 1 >= NR) ? 1 : m_addr + 1;
`endif
        end
      end else begin
        m_err = (m_err < 15) ? m_err + 1 : 15;
      end
    end
    if (s) m_state = 0;
  endtask
  task automatic step(input bit r, input bit v, input logic [7:0] d, input bit s);
    logic [7:0] rd;
    RST = r; bus.RX_VALID = v; bus.RX_DATA = d; bus.RX_STOP = s;
    @(posedge CLK);
    model(r, v, d, s);
    @(negedge CLK);
    rd = 8'h40 | ((m_addr == 0) ? 8'(IDV) : 8'(m_reg[m_addr]));
    chk("led", {2'b00, bus.LED_CTRL}, 8'(m_reg[2]));
    chk("scratch", {2'b00, bus.SCRATCH}, 8'(m_reg[1]));
    chk("wr_stb", {7'd0, bus.WR_STB}, {7'd0, m_wr});
    chk("err_cnt", {4'd0, bus.ERR_CNT}, 8'(m_err));
    chk("rd_data", bus.RD_DATA, rd);
  endtask
  initial begin
    bus.RX_VALID = 1'b0; bus.RX_DATA = 8'h00; bus.RX_STOP = 1'b0;
    @(negedge CLK);
    step(1, 0, 8'h00, 0);
    chk("reset_rd", bus.RD_DATA, 8'h6A);
    chk("reset_err", {4'd0, bus.ERR_CNT}, 8'h00);
    step(0, 1, 8'h02, 0);
    step(0, 1, 8'h41, 0);
    chk("r32_led", {2'b00, bus.LED_CTRL}, 8'h01);
    chk("r32_wr", {7'd0, bus.WR_STB}, 8'h01);
    step(0, 0, 8'h00, 1);
    chk("r32_wr_once", {7'd0, bus.WR_STB}, 8'h00);
    step(0, 1, 8'h45, 0);
    chk("r32_idle_err", {4'd0, bus.ERR_CNT}, 8'h01);
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h41, 0);
    chk("r33_led", {2'b00, bus.LED_CTRL}, 8'h00);
    chk("r33_err", {4'd0, bus.ERR_CNT}, 8'h01);
    chk("r33_wr", {7'd0, bus.WR_STB}, 8'h00);
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h05, 0);
    step(0, 1, 8'h7F, 0);
    chk("r34_err", {4'd0, bus.ERR_CNT}, 8'h02);
    chk("r34_scr", {2'b00, bus.SCRATCH}, 8'h00);
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h4A, 0);
    step(0, 1, 8'h43, 0);
    step(0, 1, 8'h55, 0);
`ifdef REGDEC_AUTOINC_EN
    chk("r35_scr", {2'b00, bus.SCRATCH}, 8'h0A);
    chk("r35_led", {2'b00, bus.LED_CTRL}, 8'h03);
    chk("r35_wrap", bus.RD_DATA, 8'h4A);
    step(0, 1, 8'h03, 0);
    chk("r35_reg3", bus.RD_DATA, 8'h55);
`else
    chk("r35_scr", {2'b00, bus.SCRATCH}, 8'h15);
    chk("r35_led", {2'b00, bus.LED_CTRL}, 8'h00);
    step(0, 1, 8'h03, 0);
    chk("r35_reg3", bus.RD_DATA, 8'h40);
`endif
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 8'hC0, 0);
    chk("r36_sat", {4'd0, bus.ERR_CNT}, 8'h0F);
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h02, 0);
    step(1, 1, 8'h42, 0);
    chk("r37_led", {2'b00, bus.LED_CTRL}, 8'h00);
    chk("r37_rd", bus.RD_DATA, 8'h6A);
    step(0, 1, 8'h02, 1);
    step(0, 1, 8'h47, 0);
    chk("stop_coincide", {4'd0, bus.ERR_CNT}, 8'h01);
    for (int i = 0; i < 600; i++) begin
      int t;
      logic [7:0] d;
      t = $urandom_range(0, 7);
      if (t < 3) d = {2'b00, 6'($urandom_range(0, 5))};
      else if (t < 6) d = {2'b01, 6'($urandom)};
      else d = {2'($urandom_range(2, 3)), 6'($urandom)};
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, d, $urandom_range(0, 7) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pif_regdecode.md
PIF_REGDECODE -- requirements
Module: pif_regdecode

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of implemented registers (2..64).
REQ-002 SHALL have parameter ID_VALUE, default 6'h2A, read-only contents of register 0.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port RX_VALID  input  1  one-cycle strobe: RX_DATA holds a received I2C write byte.
REQ-006 SHALL have port RX_DATA  input  8  received byte; [7:6] tag, [5:0] payload (`I2C_DATA_BITS`=6).
REQ-007 SHALL have port RX_STOP  input  1  one-cycle strobe: I2C STOP detected.
REQ-008 SHALL have port LED_CTRL  output  6  contents of register 2 (LED mode to flash controller).
REQ-009 SHALL have port SCRATCH  output  6  contents of register 1.
REQ-010 SHALL have port WR_STB  output  1  one-cycle pulse per accepted register write.
REQ-011 SHALL have port RD_DATA  output  8  {2'b01, contents of register at current address}, for I2C readback.
REQ-012 SHALL have port ERR_CNT  output  4  saturating count of rejected bytes.

Function
REQ-013 SHALL decode tags: 2'b00 (`A_ADDR`) = set address, 2'b01 (`D_ADDR`) = write data, 2'b10 and 2'b11 = reserved.
REQ-014 SHALL implement FSM states IDLE, ARMED, DROP; reset state IDLE.
REQ-015 SHALL, on `A_ADDR` byte with payload < NUM_REGS in any state, load address and go ARMED.
REQ-016 SHALL, on `A_ADDR` byte with payload >= NUM_REGS, leave address unchanged, increment ERR_CNT, go DROP.
REQ-017 SHALL, on `D_ADDR` byte in ARMED, write payload to addressed register, pulse WR_STB next cycle, register outputs updated the cycle after RX_VALID.
REQ-018 SHALL ignore writes to register 0 (read-only) without an error and without WR_STB.
REQ-019 SHALL, on `D_ADDR` byte in IDLE or DROP, discard it and increment ERR_CNT.
REQ-020 SHALL discard reserved-tag bytes in any state, increment ERR_CNT, keep state.
REQ-021 SHALL saturate ERR_CNT at 4'hF.
REQ-022 SHALL, on RX_STOP, go IDLE and retain address and register contents.
REQ-023 SHALL, when RX_VALID and RX_STOP coincide, process the byte first, then go IDLE in the same cycle.
REQ-024 SHALL present RD_DATA combinationally from current address; register 0 reads ID_VALUE.

Reset
REQ-025 SHALL on RST: state IDLE, address 0, registers 1..NUM_REGS-1 cleared, LED_CTRL=0, SCRATCH=0, WR_STB=0, ERR_CNT=0.
REQ-026 SHALL give RST priority over RX_VALID/RX_STOP in the same cycle; a write in progress is lost.

Configuration
REQ-027 SHALL, with REGDEC_AUTOINC_EN defined, increment address after each accepted `D_ADDR` write; incrementing past NUM_REGS-1 wraps to 1, not 0.
REQ-028 SHALL, without REGDEC_AUTOINC_EN, keep address fixed; successive data bytes overwrite the same register.

Structure
REQ-029 SHALL take tag codes `A_ADDR`, `D_ADDR` and `I2C_DATA_BITS` from shared pifdefs.v; no local redefinition.
REQ-030 SHALL place register index constants (REG_ID=0, REG_SCRATCH=1, REG_LED=2) in pifdefs.v.
REQ-031 SHALL be a single module; FSM and register file inline, no sub-module.

Verification
REQ-032 Bytes 8'h02 then 8'h41, then RX_STOP -> LED_CTRL=6'd1 one cycle after second RX_VALID, one WR_STB pulse, state IDLE.
REQ-033 Byte 8'h41 after reset (no address) -> LED_CTRL stays 0, ERR_CNT=1, no WR_STB.
REQ-034 Byte 8'h05 (NUM_REGS=4) then 8'h7F -> ERR_CNT=2, all registers unchanged.
REQ-035 REGDEC_AUTOINC_EN: 8'h01, 8'h4A, 8'h43, 8'h55 -> SCRATCH=6'h0A, LED_CTRL=6'h03, reg3=6'h15, address wraps to 1; without macro: SCRATCH=6'h15.
REQ-036 20 reserved-tag bytes 8'hC0 -> ERR_CNT=4'hF, no wrap.
REQ-037 RST asserted same cycle as RX_VALID 8'h42 while ARMED at address 2 -> LED_CTRL=0, address 0, RD_DATA=8'h6A (ID_VALUE).
